timer_irq_ctrl: RTL and testbench

Interrupt front-end for the timer channel: watches the live 32-bit count produced by the timer counter and detects overflow, underflow and compare-match events. It keeps the detected events in sticky, write-1-to-clear status bits and drives a level interrupt toward the interrupt handler using a request/acknowledge handshake. It sits between the counter output and the interrupt controller input, in the same pclk domain as the APB register file.

---
 rtl/timer_pkg.sv | 15 +
 rtl/timer_event_det.sv | 50 +++++
 rtl/timer_irq_ctrl.sv | 81 ++++++++
 tb/tb_timer_irq_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// Shared types and event bit positions for the timer interrupt front-end.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PEND     = 2'd1,
        WAIT_CLR = 2'd2
    } irq_state_t;

    localparam int EV_OVF = 0;
    localparam int EV_UDF = 1;
    localparam int EV_CMP = 2;
    localparam int NUM_EV = 3;

endpackage : timer_pkg

// File: rtl/timer_event_det.sv
// Samples the live counter and flags overflow, underflow and compare-match
// edges as single-cycle pulses in an event vector.
module timer_event_det
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              load,
    input  logic              updown,
    input  logic [CNT_W-1:0]  tcmp,
    output logic [NUM_EV-1:0] events
);

    logic [CNT_W-1:0] cnt_reg;
    logic             load_reg;
    logic             prim_reg;
    logic             match_reg;
    logic             match;

    assign match = (cnt == tcmp);

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            cnt_reg   <= '0;
            load_reg  <= 1'b0;
            prim_reg  <= 1'b0;
            match_reg <= 1'b0;
        end else begin
            cnt_reg   <= cnt;
            load_reg  <= load;
            prim_reg  <= 1'b1;
            match_reg <= match;
        end
    end

    // match_reg remembers last cycle's compare result, so a steady match fires
    // once and a tcmp change landing on a held count still produces one pulse.
    always_comb begin
        events = '0;
        if (prim_reg && !load_reg) begin
            events[EV_OVF] = !updown && (cnt_reg == '1) && (cnt == '0);
            events[EV_UDF] =  updown && (cnt_reg == '0) && (cnt == '1);
            events[EV_CMP] = match && !match_reg;
        end
    end

endmodule : timer_event_det

// File: rtl/timer_irq_ctrl.sv
// Timer interrupt front-end: sticky W1C status flags plus a request/ack FSM
// that drives a level interrupt toward the interrupt handler.
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              pclk,
    input  logic              preset_n,
    input  logic [CNT_W-1:0]  cnt,
    input  logic              load,
    input  logic              updown,
    input  logic [CNT_W-1:0]  tcmp,
    input  logic [NUM_EV-1:0] irq_en,
    input  logic              clr_we,
    input  logic [NUM_EV-1:0] clr_mask,
    input  logic              irq_ack,
    output logic [NUM_EV-1:0] status,
    output logic              irq_o
);

    logic [NUM_EV-1:0] events;
    logic [NUM_EV-1:0] status_reg;
    logic              pending;
    irq_state_t        state_reg;
    irq_state_t        state_next;

    timer_event_det #(
        .CNT_W (CNT_W)
    ) u_event_det (
        .pclk     (pclk),
        .preset_n (preset_n),
        .cnt      (cnt),
        .load     (load),
        .updown   (updown),
        .tcmp     (tcmp),
        .events   (events)
    );

    // A new event beats a same-cycle clear so nothing is ever lost.
    generate
        for (genvar gi = 0; gi < NUM_EV; gi++) begin : g_status
            always_ff @(posedge pclk) begin
                if (!preset_n) begin
                    status_reg[gi] <= 1'b0;
                end else if (events[gi]) begin
                    status_reg[gi] <= 1'b1;
                end else if (clr_we && clr_mask[gi]) begin
                    status_reg[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign status  = status_reg;
    assign pending = |(status_reg & irq_en);

    always_ff @(posedge pclk) begin
        if (!preset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // PEND only leaves on ack: disabling irq_en never withdraws a request.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:     if (pending) state_next = PEND;
            PEND:     if (irq_ack) state_next = WAIT_CLR;
            WAIT_CLR: if (!pending) state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_comb begin
        irq_o = (state_reg == PEND);
    end

endmodule : timer_irq_ctrl

// File: tb/tb_timer_irq_ctrl.sv
// Directed bench for timer_irq_ctrl: overflow, underflow/ack, compare, load
// suppression, set/clear collision, event during PEND and mid-run reset.
module tb_timer_irq_ctrl;
    import timer_pkg::*;

    logic        pclk;
    logic        preset_n;
    logic [31:0] cnt;
    logic        load;
    logic        updown;
    logic [31:0] tcmp;
    logic [2:0]  irq_en;
    logic        clr_we;
    logic [2:0]  clr_mask;
    logic        irq_ack;
    logic [2:0]  status;
    logic        irq_o;

    int checks   = 0;
    int failures = 0;

    timer_irq_ctrl #(.CNT_W(32)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .cnt      (cnt),
        .load     (load),
        .updown   (updown),
        .tcmp     (tcmp),
        .irq_en   (irq_en),
        .clr_we   (clr_we),
        .clr_mask (clr_mask),
        .irq_ack  (irq_ack),
        .status   (status),
        .irq_o    (irq_o)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    initial begin
        preset_n = 1'b0;
        cnt      = '0;
        load     = 1'b0;
        updown   = 1'b0;
        tcmp     = 32'h0000_0005;
        irq_en   = 3'b000;
        clr_we   = 1'b0;
        clr_mask = 3'b000;
        irq_ack  = 1'b0;
        tick();
        tick();
        check("rst_status", 32'(status), 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        check("rst_state", 32'(dut.state_reg), 32'(IDLE));

        // Overflow
        preset_n = 1'b1;
        irq_en   = 3'b001;
        cnt      = 32'hFFFF_FFFE;
        tick();
        cnt = 32'hFFFF_FFFF;
        tick();
        check("ovf_pre_status", 32'(status), 32'h0);
        cnt = 32'h0000_0000;
        tick();
        check("ovf_status_n1", 32'(status), 32'h1);
        check("ovf_irq_n1", 32'(irq_o), 32'h0);
        tick();
        check("ovf_irq_n2", 32'(irq_o), 32'h1);
        clr_we = 1'b1; clr_mask = 3'b001;
        tick();
        clr_we = 1'b0; clr_mask = 3'b000;
        check("ovf_cleared", 32'(status), 32'h0);
        check("ovf_hold_pend", 32'(irq_o), 32'h1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("ovf_ack_irq", 32'(irq_o), 32'h0);
        tick();
        check("ovf_rearm_idle", 32'(dut.state_reg), 32'(IDLE));

        // Underflow and ack
        irq_en = 3'b010;
        updown = 1'b1;
        cnt    = 32'h0000_0001;
        tick();
        cnt = 32'h0000_0000;
        tick();
        cnt = 32'hFFFF_FFFF;
        tick();
        check("udf_status", 32'(status), 32'h2);
        tick();
        check("udf_irq", 32'(irq_o), 32'h1);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        check("udf_ack_irq", 32'(irq_o), 32'h0);
        check("udf_wait_clr", 32'(dut.state_reg), 32'(WAIT_CLR));
        clr_we = 1'b1; clr_mask = 3'b010;
        tick();
        clr_we = 1'b0; clr_mask = 3'b000;
        check("udf_cleared", 32'(status), 32'h0);
        tick();
        check("udf_idle", 32'(dut.state_reg), 32'(IDLE));
        check("udf_irq_low", 32'(irq_o), 32'h0);

        // Compare: count up through 0x10 then hold
        irq_en = 3'b100;
        updown = 1'b0;
        tcmp   = 32'h0000_0010;
        cnt    = 32'h0000_000E;
        tick();
        cnt = 32'h0000_000F;
        tick();
        cnt = 32'h0000_0010;
        tick();
        check("cmp_status", 32'(status), 32'h4);
        tick();
        check("cmp_irq", 32'(irq_o), 32'h1);
        clr_we = 1'b1; clr_mask = 3'b100;
        tick();
        clr_we = 1'b0; clr_mask = 3'b000;
        check("cmp_cleared", 32'(status), 32'h0);
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        tick();
        check("cmp_hold_no_reset", 32'(status), 32'h0);
        check("cmp_idle", 32'(dut.state_reg), 32'(IDLE));
        check("cmp_irq_low", 32'(irq_o), 32'h0);

        // Set-versus-clear collision, with events masked
        irq_en = 3'b000;
        cnt    = 32'hFFFF_FFFF;
        tick();
        cnt = 32'h0000_0000;
        clr_we = 1'b1; clr_mask = 3'b001;
        tick();
        clr_we = 1'b0; clr_mask = 3'b000;
        check("collide_set_wins", 32'(status), 32'h1);
        tick();
        check("masked_irq_low", 32'(irq_o), 32'h0);

        // Load suppression
        clr_we = 1'b1; clr_mask = 3'b111;
        tick();
        clr_we = 1'b0; clr_mask = 3'b000;
        cnt  = 32'hFFFF_FFFF;
        load = 1'b1;
        tick();
        load = 1'b0;
        cnt  = 32'h0000_0000;
        tick();
        tick();
        check("load_suppress", 32'(status), 32'h0);

        // Event during PEND, irq_en drop without withdrawal
        irq_en = 3'b001;
        cnt    = 32'hFFFF_FFFF;
        tick();
        cnt = 32'h0000_0000;
        tick();
        tick();
        check("pend_irq", 32'(irq_o), 32'h1);
        irq_en = 3'b000;
        updown = 1'b1;
        cnt    = 32'hFFFF_FFFF;
        tick();
        check("pend_no_withdraw", 32'(irq_o), 32'h1);
        check("pend_event_status", 32'(status), 32'h3);

        // Reset mid-operation, first post-reset sample must not fire
        preset_n = 1'b0;
        tick();
        check("mid_rst_status", 32'(status), 32'h0);
        check("mid_rst_irq", 32'(irq_o), 32'h0);
        check("mid_rst_state", 32'(dut.state_reg), 32'(IDLE));
        preset_n = 1'b1;
        irq_en   = 3'b111;
        tick();
        check("post_rst_no_fire", 32'(status), 32'h0);
        tick();
        check("post_rst_quiet", 32'(status), 32'h0);
        check("post_rst_irq", 32'(irq_o), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_timer_irq_ctrl
